// File: rtl/fsm_dispatch_pkg.sv
// Shared definitions for the field dispatcher: state encodings, word layout,
// index width and varint length limit.
package fsm_dispatch_pkg;

    localparam int IDX_W      = 10;
    localparam int WORD_W     = 10;
    localparam int LAST_BIT   = 9;
    localparam int VARINT_BIT = 8;
    localparam int BYTE_W     = 8;
    localparam int VARINT_MAX = 10;
    localparam int CNT_W      = 4;

    typedef enum logic [7:0] {
        INIT      = 8'b0000_0001,
        WAIT_DATA = 8'b0000_0010,
        POP       = 8'b0000_0100,
        LATCH     = 8'b0000_1000,
        V_PUSH    = 8'b0001_0000,
        R_PUSH    = 8'b0010_0000,
        V_FULL    = 8'b0100_0000,
        R_FULL    = 8'b1000_0000
    } state_t;

endpackage

// File: rtl/dispatch_index_ctr.sv
// Field index and varint byte counter; the index advances after a field's last
// byte is pushed, and the overflow flag is sticky until reset.
module dispatch_index_ctr
    import fsm_dispatch_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             push,
    input  logic             push_last,
    input  logic             push_varint,
    output logic [IDX_W-1:0] index,
    output logic             overflow
);

    logic [CNT_W-1:0] byte_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            index    <= '0;
            byte_cnt <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            index    <= '0;
            byte_cnt <= '0;
        end else if (push) begin
            if (push_last) begin
                // Natural 10-bit wrap takes 1023 back to 0.
                index    <= index + 1'b1;
                byte_cnt <= '0;
            end else if (push_varint) begin
                if (byte_cnt != '1) begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
                if (byte_cnt >= CNT_W'(VARINT_MAX)) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fsm_dispatch.sv
// Pulls tagged bytes from the input FIFO and routes each one to the varint or
// raw downstream FIFO, stamping it with the index of the field it belongs to.
module fsm_dispatch
    import fsm_dispatch_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_fifo_empty,
    input  logic [9:0]       in_fifo_q,
    output logic             in_fifo_pop,
    output logic             in_fifo_clr,
    input  logic             varint_fifo_full,
    input  logic             raw_fifo_full,
    output logic             varint_fifo_push,
    output logic             raw_fifo_push,
    output logic [7:0]       varint_fifo_d,
    output logic [7:0]       raw_fifo_d,
    output logic [9:0]       varint_in_index_d,
    output logic [9:0]       raw_data_in_index_d,
    output logic             varint_overflow,
    output logic [7:0]       state_dbg
);

    state_t            state, state_next;
    logic [WORD_W-1:0] latch_q;
    logic              v_push, r_push;
    logic [IDX_W-1:0]  index;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            latch_q <= '0;
        end else if (state == INIT) begin
            latch_q <= '0;
        end else if (state == LATCH) begin
            latch_q <= in_fifo_q;
        end
    end

    // Handshake: a downstream push is a one-cycle strobe that only fires while
    // that FIFO's full is low; a full seen in a push state falls back to the stall.
    always_comb begin
        state_next = state;
        v_push     = 1'b0;
        r_push     = 1'b0;
        case (state)
            INIT:      state_next = WAIT_DATA;
            WAIT_DATA: if (!in_fifo_empty) state_next = POP;
            POP:       state_next = LATCH;
            LATCH: begin
                if (in_fifo_q[VARINT_BIT]) begin
                    state_next = varint_fifo_full ? V_FULL : V_PUSH;
                end else begin
                    state_next = raw_fifo_full ? R_FULL : R_PUSH;
                end
            end
            V_FULL:    if (!varint_fifo_full) state_next = V_PUSH;
            R_FULL:    if (!raw_fifo_full) state_next = R_PUSH;
            V_PUSH: begin
                if (varint_fifo_full) begin
                    state_next = V_FULL;
                end else begin
                    v_push     = 1'b1;
                    state_next = WAIT_DATA;
                end
            end
            R_PUSH: begin
                if (raw_fifo_full) begin
                    state_next = R_FULL;
                end else begin
                    r_push     = 1'b1;
                    state_next = WAIT_DATA;
                end
            end
            default:   state_next = INIT;
        endcase
    end

    dispatch_index_ctr u_index_ctr (
        .clk         (clk),
        .reset       (reset),
        .clr         (state == INIT),
        .push        (v_push | r_push),
        .push_last   (latch_q[LAST_BIT]),
        .push_varint (latch_q[VARINT_BIT]),
        .index       (index),
        .overflow    (varint_overflow)
    );

    assign in_fifo_pop         = reset && (state == POP);
    assign in_fifo_clr         = reset && (state == INIT);
    assign varint_fifo_push    = reset && v_push;
    assign raw_fifo_push       = reset && r_push;
    assign varint_fifo_d       = varint_fifo_push ? latch_q[BYTE_W-1:0] : '0;
    assign raw_fifo_d          = raw_fifo_push ? latch_q[BYTE_W-1:0] : '0;
    assign varint_in_index_d   = varint_fifo_push ? index : '0;
    assign raw_data_in_index_d = raw_fifo_push ? index : '0;
    assign state_dbg           = state;

endmodule
